serial_word_scanner: RTL and testbench

- Parallel-to-serial front end for the 32:1 bit-select multiplexer.
- Accepts a 32-bit word plus a bit count over a valid/ready handshake, holds the word on the mux data inputs, and steps the mux select through the requested bits once per accepted beat.
- Returns the selected bit to a downstream consumer on a serial valid/ready interface with a last flag.

---
 rtl/serial_word_scanner_pkg.sv | 15 +
 rtl/serial_word_scanner.sv | 98 +++++++++
 tb/tb_serial_word_scanner.sv | 338 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/serial_word_scanner_pkg.sv
// Shared definitions for the serial word scanner: default geometry of the
// external 32:1 bit-select mux and the two-state controller encoding.
package serial_word_scanner_pkg;

    // Default word width; must match the data width of the external mux.
    localparam int WIDTH_DEFAULT = 32;

    // Default select width, log2 of the word width.
    localparam int SEL_W_DEFAULT = 5;

    // Controller states: waiting for a word, or streaming its bits out.
    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_SHIFT = 1'b1;

endpackage

// File: rtl/serial_word_scanner.sv
// Serial word scanner: accepts a word plus a bit count, parks the word on the
// data inputs of an external bit-select mux and walks the mux select through
// the requested bits, presenting one selected bit per accepted serial beat.
// The mux is combinational and lives outside this block, so ser_data is a
// straight wire from mux_out and there is no added latency on the bit path.
module serial_word_scanner
    import serial_word_scanner_pkg::*;
#(
    parameter int WIDTH     = WIDTH_DEFAULT,
    parameter int SEL_W     = SEL_W_DEFAULT,
    parameter int MSB_FIRST = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_valid,
    output logic             load_ready,
    input  logic [WIDTH-1:0] load_data,
    input  logic [SEL_W-1:0] load_len,
    output logic [WIDTH-1:0] mux_in,
    output logic [SEL_W-1:0] mux_sel,
    input  logic             mux_out,
    output logic             ser_valid,
    input  logic             ser_ready,
    output logic             ser_data,
    output logic             ser_last,
    output logic             done
);

    logic [0:0]       state;
    logic [SEL_W-1:0] remaining;
    logic             in_shift;
    logic             beat;
    logic             last_beat;
    logic             load_fire;
    logic [SEL_W-1:0] first_sel;
    logic [SEL_W-1:0] next_sel;

    // Handshake decode: a new word may enter while idle, or in the very cycle
    // the final bit of the current word is taken, which keeps back-to-back
    // words free of bubbles.
    always_comb begin
        in_shift   = (state == ST_SHIFT);
        beat       = in_shift && ser_ready;
        last_beat  = beat && (remaining == '0);
        load_ready = !in_shift || last_beat;
        load_fire  = load_valid && load_ready;
        ser_valid  = in_shift;
        ser_last   = in_shift && (remaining == '0);
        ser_data   = mux_out;
    end

    // Select stepping: LSB-first starts at bit 0 and counts up to load_len,
    // MSB-first starts at load_len and counts down to 0, so the index never
    // wraps even for a full-width word.
    always_comb begin
        if (MSB_FIRST != 0) begin
            first_sel = load_len;
            next_sel  = mux_sel - SEL_W'(1);
        end else begin
            first_sel = '0;
            next_sel  = mux_sel + SEL_W'(1);
        end
    end

    // Controller state and the done pulse; reset drops any word in flight
    // without announcing it.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
            done  <= 1'b0;
        end else begin
            done <= last_beat;
            if (load_fire) begin
                state <= ST_SHIFT;
            end else if (last_beat) begin
                state <= ST_IDLE;
            end
        end
    end

    // Word, select and remaining-count registers; everything holds while the
    // consumer stalls so the presented bit stays stable.
    always_ff @(posedge clk) begin
        if (rst) begin
            mux_in    <= '0;
            mux_sel   <= '0;
            remaining <= '0;
        end else if (load_fire) begin
            mux_in    <= load_data;
            mux_sel   <= first_sel;
            remaining <= load_len;
        end else if (beat && !last_beat) begin
            mux_sel   <= next_sel;
            remaining <= remaining - SEL_W'(1);
        end
    end

endmodule

// File: tb/tb_serial_word_scanner.sv
// Testbench for serial_word_scanner: one LSB-first and one MSB-first instance,
// each with a behavioural 32:1 mux, checked every cycle against a queue-based
// model of the expected bit stream plus directed literal expectations.
module tb_serial_word_scanner;

    typedef struct packed {
        logic       bit_v;
        logic [4:0] sel;
        logic       last;
    } beat_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  load_valid;
    logic [1:0]  load_ready;
    logic [1:0]  ser_valid;
    logic [1:0]  ser_ready;
    logic [1:0]  ser_data;
    logic [1:0]  ser_last;
    logic [1:0]  done;
    logic [1:0]  mux_out;
    logic [31:0] load_data [2];
    logic [31:0] mux_in    [2];
    logic [4:0]  load_len  [2];
    logic [4:0]  mux_sel   [2];

    // Bench control and bookkeeping.
    logic [1:0]  ready_mode;
    int          check_count = 0;
    int          pass_count  = 0;
    int          cyc         = 0;

    // Behavioural model state: queue of beats still to be presented.
    beat_t       mq [2][$];
    logic [31:0] word_m    [2];
    logic [1:0]  done_pend;
    logic [1:0]  fresh;
    logic [1:0]  armed;

    // Captured accepted beats for directed checks.
    logic        cap_bit [2][$];
    logic [4:0]  cap_sel [2][$];
    int          cap_cyc [2][$];
    int          last_cnt [2];
    int          last_pos [2];
    int          done_cnt [2];

    serial_word_scanner #(.WIDTH(32), .SEL_W(5), .MSB_FIRST(0)) dut_lsb (
        .clk(clk), .rst(rst),
        .load_valid(load_valid[0]), .load_ready(load_ready[0]),
        .load_data(load_data[0]), .load_len(load_len[0]),
        .mux_in(mux_in[0]), .mux_sel(mux_sel[0]), .mux_out(mux_out[0]),
        .ser_valid(ser_valid[0]), .ser_ready(ser_ready[0]),
        .ser_data(ser_data[0]), .ser_last(ser_last[0]), .done(done[0])
    );

    serial_word_scanner #(.WIDTH(32), .SEL_W(5), .MSB_FIRST(1)) dut_msb (
        .clk(clk), .rst(rst),
        .load_valid(load_valid[1]), .load_ready(load_ready[1]),
        .load_data(load_data[1]), .load_len(load_len[1]),
        .mux_in(mux_in[1]), .mux_sel(mux_sel[1]), .mux_out(mux_out[1]),
        .ser_valid(ser_valid[1]), .ser_ready(ser_ready[1]),
        .ser_data(ser_data[1]), .ser_last(ser_last[1]), .done(done[1])
    );

    // External bit-select muxes.
    assign mux_out[0] = mux_in[0][mux_sel[0]];
    assign mux_out[1] = mux_in[1][mux_sel[1]];

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        check_count++;
        if (act !== exp) begin
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end else begin
            pass_count++;
        end
    endtask

    task automatic timeoutFail(input string name);
        check_count++;
        $display("[TB] FAIL %s: timed out, got no completion expected completion", name);
    endtask

    // Consumer ready: held high, or a fair coin each cycle.
    initial begin
        ser_ready = 2'b11;
        forever begin
            @(posedge clk);
            #1;
            for (int d = 0; d < 2; d++) begin
                ser_ready[d] = ready_mode[d] ? 1'($urandom_range(0, 1)) : 1'b1;
            end
        end
    end

    // Per-cycle model compare, beat capture and model advance.
    always @(negedge clk) begin
        cyc++;
        for (int d = 0; d < 2; d++) begin
            logic  has;
            logic  exp_lr;
            beat_t f;
            has    = (mq[d].size() != 0);
            f      = has ? mq[d][0] : beat_t'('0);
            exp_lr = !has || (f.last && ser_ready[d]);
            if (armed[d]) begin
                checkOutput($sformatf("ser_valid[%0d]", d), 64'(ser_valid[d]), 64'(has));
                checkOutput($sformatf("load_ready[%0d]", d), 64'(load_ready[d]), 64'(exp_lr));
                checkOutput($sformatf("done[%0d]", d), 64'(done[d]), 64'(done_pend[d]));
                if (has) begin
                    checkOutput($sformatf("ser_data[%0d]", d), 64'(ser_data[d]), 64'(f.bit_v));
                    checkOutput($sformatf("ser_last[%0d]", d), 64'(ser_last[d]), 64'(f.last));
                    checkOutput($sformatf("mux_sel[%0d]", d), 64'(mux_sel[d]), 64'(f.sel));
                    checkOutput($sformatf("mux_in[%0d]", d), 64'(mux_in[d]), 64'(word_m[d]));
                end else if (fresh[d]) begin
                    checkOutput($sformatf("idle_mux_in[%0d]", d), 64'(mux_in[d]), 64'd0);
                    checkOutput($sformatf("idle_mux_sel[%0d]", d), 64'(mux_sel[d]), 64'd0);
                end
                if (ser_valid[d] && ser_ready[d] && !rst) begin
                    if (ser_last[d]) begin
                        last_cnt[d]++;
                        last_pos[d] = cap_bit[d].size();
                    end
                    cap_bit[d].push_back(ser_data[d]);
                    cap_sel[d].push_back(mux_sel[d]);
                    cap_cyc[d].push_back(cyc);
                end
                if (done[d]) done_cnt[d]++;
            end
            if (rst) begin
                mq[d].delete();
                done_pend[d] = 1'b0;
                fresh[d]     = 1'b1;
                armed[d]     = 1'b1;
            end else begin
                done_pend[d] = has && ser_ready[d] && f.last;
                if (has && ser_ready[d]) void'(mq[d].pop_front());
                if (load_valid[d] && exp_lr) begin
                    word_m[d] = load_data[d];
                    fresh[d]  = 1'b0;
                    for (int i = 0; i <= int'(load_len[d]); i++) begin
                        beat_t b;
                        int    idx;
                        idx     = (d == 0) ? i : int'(load_len[d]) - i;
                        b.bit_v = load_data[d][idx];
                        b.sel   = 5'(idx);
                        b.last  = (i == int'(load_len[d]));
                        mq[d].push_back(b);
                    end
                end
            end
        end
    end

    task automatic clearCap();
        for (int d = 0; d < 2; d++) begin
            cap_bit[d].delete();
            cap_sel[d].delete();
            cap_cyc[d].delete();
            last_cnt[d] = 0;
            last_pos[d] = -1;
            done_cnt[d] = 0;
        end
    endtask

    // Offer one word and hold it until the DUT takes it.
    task automatic applyStimulus(input int d, input logic [31:0] data, input logic [4:0] len);
        int n;
        load_valid[d] = 1'b1;
        load_data[d]  = data;
        load_len[d]   = len;
        for (n = 0; n < 2000; n++) begin
            @(negedge clk);
            if (load_ready[d]) break;
        end
        if (n == 2000) timeoutFail($sformatf("load_accept[%0d]", d));
        @(posedge clk);
        #1;
        load_valid[d] = 1'b0;
        load_data[d]  = $urandom;
        load_len[d]   = 5'($urandom);
    endtask

    task automatic waitIdle(input int d);
        int n;
        for (n = 0; n < 4000; n++) begin
            @(negedge clk);
            if (!ser_valid[d] && !load_valid[d]) break;
        end
        if (n == 4000) timeoutFail($sformatf("drain[%0d]", d));
        @(negedge clk);
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] packLsb(input int d, input int cnt);
        logic [31:0] w;
        w = '0;
        for (int i = 0; i < cnt && i < cap_bit[d].size() && i < 32; i++) w[i] = cap_bit[d][i];
        return w;
    endfunction

    initial begin
        int sel_err;
        logic [4:0]  bits5;
        logic [24:0] sels25;
        rst        = 1'b1;
        load_valid = 2'b00;
        ready_mode = 2'b00;
        armed      = 2'b00;
        fresh      = 2'b11;
        done_pend  = 2'b00;
        for (int d = 0; d < 2; d++) begin
            load_data[d] = $urandom;
            load_len[d]  = 5'($urandom);
        end
        clearCap();
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;

        // Reset state, pinned with literals.
        @(negedge clk);
        checkOutput("reset_load_ready", 64'(load_ready), 64'h3);
        checkOutput("reset_ser_valid", 64'(ser_valid), 64'h0);
        checkOutput("reset_ser_last", 64'(ser_last), 64'h0);
        checkOutput("reset_done", 64'(done), 64'h0);
        checkOutput("reset_mux_in", 64'(mux_in[0]), 64'h0);
        checkOutput("reset_mux_sel", 64'(mux_sel[1]), 64'h0);
        @(posedge clk);
        #1;

        $display("[TB] full word LSB-first");
        clearCap();
        applyStimulus(0, 32'hA5A5_0F0F, 5'd31);
        waitIdle(0);
        checkOutput("t1_beats", 64'(cap_bit[0].size()), 64'd32);
        checkOutput("t1_word", 64'(packLsb(0, 32)), 64'hA5A5_0F0F);
        checkOutput("t1_last_cnt", 64'(last_cnt[0]), 64'd1);
        checkOutput("t1_last_pos", 64'(last_pos[0]), 64'd31);
        checkOutput("t1_done_cnt", 64'(done_cnt[0]), 64'd1);
        sel_err = 0;
        for (int i = 0; i < cap_sel[0].size(); i++) if (int'(cap_sel[0][i]) != i) sel_err++;
        checkOutput("t1_sel_ramp_errors", 64'(sel_err), 64'd0);

        $display("[TB] short word MSB-first");
        clearCap();
        applyStimulus(1, 32'h0000_0013, 5'd4);
        waitIdle(1);
        bits5  = '0;
        sels25 = '0;
        for (int i = 0; i < cap_bit[1].size() && i < 5; i++) begin
            bits5  = {bits5[3:0], cap_bit[1][i]};
            sels25 = {sels25[19:0], cap_sel[1][i]};
        end
        checkOutput("t2_beats", 64'(cap_bit[1].size()), 64'd5);
        checkOutput("t2_bits", 64'(bits5), 64'(5'b10011));
        checkOutput("t2_sels", 64'(sels25), 64'({5'd4, 5'd3, 5'd2, 5'd1, 5'd0}));
        checkOutput("t2_done_cnt", 64'(done_cnt[1]), 64'd1);
        checkOutput("t2_idle", 64'(ser_valid[1]), 64'd0);

        $display("[TB] single-bit word");
        clearCap();
        applyStimulus(0, 32'h0000_0001, 5'd0);
        waitIdle(0);
        checkOutput("t3_beats", 64'(cap_bit[0].size()), 64'd1);
        checkOutput("t3_bit", 64'(packLsb(0, 1)), 64'd1);
        checkOutput("t3_last_pos", 64'(last_pos[0]), 64'd0);
        checkOutput("t3_done_cnt", 64'(done_cnt[0]), 64'd1);

        $display("[TB] random stalls");
        clearCap();
        ready_mode[0] = 1'b1;
        applyStimulus(0, 32'hDEAD_BEEF, 5'd31);
        waitIdle(0);
        ready_mode[0] = 1'b0;
        checkOutput("t4_word", 64'(packLsb(0, 32)), 64'hDEAD_BEEF);
        checkOutput("t4_done_cnt", 64'(done_cnt[0]), 64'd1);

        $display("[TB] back-to-back words");
        clearCap();
        applyStimulus(0, 32'hFFFF_FFFF, 5'd7);
        applyStimulus(0, 32'h0000_0000, 5'd7);
        waitIdle(0);
        checkOutput("t5_beats", 64'(cap_bit[0].size()), 64'd16);
        checkOutput("t5_bits", 64'(packLsb(0, 16)), 64'h0000_00FF);
        if (cap_cyc[0].size() == 16)
            checkOutput("t5_span", 64'(cap_cyc[0][15] - cap_cyc[0][0]), 64'd15);
        else
            checkOutput("t5_span_beats", 64'(cap_cyc[0].size()), 64'd16);
        checkOutput("t5_done_cnt", 64'(done_cnt[0]), 64'd2);

        $display("[TB] reset mid-word");
        applyStimulus(0, 32'h1234_5678, 5'd31);
        repeat (9) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        clearCap();
        @(negedge clk);
        checkOutput("t6_ser_valid", 64'(ser_valid[0]), 64'd0);
        checkOutput("t6_load_ready", 64'(load_ready[0]), 64'd1);
        checkOutput("t6_mux_sel", 64'(mux_sel[0]), 64'd0);
        checkOutput("t6_mux_in", 64'(mux_in[0]), 64'd0);
        checkOutput("t6_done", 64'(done[0]), 64'd0);
        repeat (4) @(negedge clk);
        checkOutput("t6_done_cnt", 64'(done_cnt[0]), 64'd0);
        @(posedge clk);
        #1;

        $display("[TB] randomized words");
        ready_mode = 2'b11;
        for (int k = 0; k < 16; k++) begin
            int d;
            d = k % 2;
            applyStimulus(d, $urandom, 5'($urandom_range(0, 31)));
            if ($urandom_range(0, 1) == 1) applyStimulus(d, $urandom, 5'($urandom_range(0, 31)));
            waitIdle(d);
        end
        ready_mode = 2'b00;
        repeat (2) @(posedge clk);

        $display("%0d/%0d checks passed", pass_count, check_count);
        $finish;
    end

    // Global watchdog so the run always terminates.
    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation still running, expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
